inst_sram_bridge: RTL and testbench



---
 rtl/cpu_defines_pkg.sv | 15 +
 rtl/inst_addr_map.sv | 18 +
 rtl/inst_sram_bridge.sv | 134 +++++++++++++
 tb/tb_inst_sram_bridge.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defines_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and address-map constants.
package cpu_defines_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  SIZE_WORD  = 2'b10;
    localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;
    localparam logic [1:0]  KSEG01_TAG = 2'b10;

endpackage

// File: rtl/inst_addr_map.sv
// Virtual-to-physical address map: kseg0/kseg1 fold onto physical by clearing the top three bits.
module inst_addr_map
    import cpu_defines_pkg::*;
#(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        paddr = vaddr;
        if (ADDR_MAP_EN && (vaddr[31:30] == KSEG01_TAG)) begin
            paddr = vaddr & KSEG_MASK;
        end
    end

endmodule

// File: rtl/inst_sram_bridge.sv
// Instruction-fetch bridge: turns each IF fetch into one SRAM-like bus read and holds the
// front end until the instruction for the current pc_i is available.
module inst_sram_bridge
    import cpu_defines_pkg::*;
#(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        inst_req_o,
    output logic        inst_wr_o,
    output logic [1:0]  inst_size_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_wdata_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        inst_adel_o,
    output logic        stall_req_o,
    output logic [1:0]  dbg_state
);

    // Bus handshake: a request is held (req with stable addr) until addr_ok;
    // exactly one data_ok follows each accepted address, and only one is outstanding.

    fetch_state_t state, next_state;
    logic         discard, next_discard;
    logic         adel, next_adel;
    logic [31:0]  buf_pc, next_buf_pc;
    logic [31:0]  buffer, next_buffer;
    logic [31:0]  addr, next_addr;
    logic [31:0]  paddr;
    logic         pc_hit;

    inst_addr_map #(.ADDR_MAP_EN(ADDR_MAP_EN)) u_addr_map (
        .vaddr (pc_i),
        .paddr (paddr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            discard <= 1'b0;
            adel    <= 1'b0;
            buf_pc  <= 32'h0;
            buffer  <= 32'h0;
            addr    <= 32'h0;
        end else begin
            state   <= next_state;
            discard <= next_discard;
            adel    <= next_adel;
            buf_pc  <= next_buf_pc;
            buffer  <= next_buffer;
            addr    <= next_addr;
        end
    end

    always_comb begin
        next_state   = state;
        next_discard = discard;
        next_adel    = adel;
        next_buf_pc  = buf_pc;
        next_buffer  = buffer;
        next_addr    = addr;
        case (state)
            IDLE: begin
                if (ce_i && !flush_i) begin
                    next_buf_pc = pc_i;
                    if (pc_i[1:0] == 2'b00) begin
                        next_addr  = paddr;
                        next_adel  = 1'b0;
                        next_state = REQ;
                    end else begin
                        // Misaligned fetch never reaches the bus; report it as a zero instruction.
                        next_buffer = 32'h0;
                        next_adel   = 1'b1;
                        next_state  = DONE;
                    end
                end
            end
            REQ: begin
                if (flush_i) begin
                    next_discard = 1'b1;
                end
                if (inst_addr_ok_i) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (inst_data_ok_i) begin
                    next_buffer = inst_rdata_i;
                    // A flush arriving together with data_ok kills that data as well.
                    if (discard || flush_i) begin
                        next_discard = 1'b0;
                        next_state   = IDLE;
                    end else begin
                        next_state = DONE;
                    end
                end else if (flush_i) begin
                    next_discard = 1'b1;
                end
            end
            DONE: begin
                if (flush_i || !stall_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign pc_hit       = (buf_pc == pc_i);
    assign inst_req_o   = (state == REQ);
    assign inst_wr_o    = 1'b0;
    assign inst_size_o  = SIZE_WORD;
    assign inst_addr_o  = addr;
    assign inst_wdata_o = 32'h0;
    assign inst_o       = (state == DONE) ? buffer : 32'h0;
    assign inst_adel_o  = (state == DONE) && adel;
    assign inst_valid_o = (state == DONE) && pc_hit && ce_i;
    assign stall_req_o  = ce_i && !((state == DONE) && pc_hit && !discard);
    assign dbg_state    = state;

    data_ok_only_in_wait: assert property (
        @(posedge clk_i) disable iff (rst_i) inst_data_ok_i |-> (state == WAIT)
    );

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Bench for inst_sram_bridge: behavioural SRAM-like slave, fetch scoreboard, vector table
// plus hand-written sequences for latency, flush and reset corners.
module tb_inst_sram_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        ce_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        inst_req_o;
    logic        inst_wr_o;
    logic [1:0]  inst_size_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_wdata_o;
    logic        inst_addr_ok_i = 1'b0;
    logic        inst_data_ok_i = 1'b0;
    logic [31:0] inst_rdata_i = 32'h0;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_adel_o;
    logic        stall_req_o;
    logic [1:0]  dbg_state;

    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;

    inst_sram_bridge #(.ADDR_MAP_EN(1'b1)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_i           (pc_i),
        .ce_i           (ce_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .inst_req_o     (inst_req_o),
        .inst_wr_o      (inst_wr_o),
        .inst_size_o    (inst_size_o),
        .inst_addr_o    (inst_addr_o),
        .inst_wdata_o   (inst_wdata_o),
        .inst_addr_ok_i (inst_addr_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .inst_rdata_i   (inst_rdata_i),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o),
        .inst_adel_o    (inst_adel_o),
        .stall_req_o    (stall_req_o),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // {pc, adel, inst} of each fetch the pipeline must consume, in order
    logic [64:0] exp_q[$];
    // physical address of each bus request the slave must accept, in order
    logic [31:0] exp_addr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'h3C08_BFC0;
        return (a ^ 32'hC0DE_0000) + 32'h1;
    endfunction

    // ---------------- SRAM-like slave ----------------
    int          addr_delay = 0;
    int          data_delay = 0;
    int          acnt = 0;
    int          dcnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] held_addr = 32'h0;
    logic        last_acc = 1'b0;
    logic        last_dok = 1'b0;
    logic [31:0] last_addr = 32'h0;

    always @(posedge clk_i) begin
        #1;
        if (rst_i) begin
            pend = 1'b0; acnt = 0; dcnt = 0;
            last_acc = 1'b0; last_dok = 1'b0;
            inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = 32'h0;
        end else begin
            if (last_dok) pend = 1'b0;
            if (last_acc) begin
                pend = 1'b1; pend_addr = last_addr; dcnt = 0;
                chk("req_drops_after_addr_ok", {31'h0, inst_req_o}, 32'h0);
            end
            inst_data_ok_i = 1'b0;
            inst_rdata_i   = 32'h0;
            if (pend) begin
                if (dcnt >= data_delay) begin
                    inst_data_ok_i = 1'b1;
                    inst_rdata_i   = mem_data(pend_addr);
                end else begin
                    dcnt++;
                end
            end
            inst_addr_ok_i = 1'b0;
            if (inst_req_o) begin
                if (acnt == 0) held_addr = inst_addr_o;
                else chk("addr_stable", inst_addr_o, held_addr);
                if (acnt >= addr_delay) begin
                    inst_addr_ok_i = 1'b1;
                    acnt = 0;
                    if (exp_addr_q.size() == 0) chk("unexpected_request", inst_addr_o, 32'hFFFF_FFFF);
                    else chk("req_addr", inst_addr_o, exp_addr_q.pop_front());
                end else begin
                    acnt++;
                end
            end else begin
                acnt = 0;
            end
            last_acc  = inst_req_o && inst_addr_ok_i;
            last_addr = inst_addr_o;
            last_dok  = inst_data_ok_i;
        end
    end

    // ---------------- scoreboard: compare on each consumed instruction ----------------
    always @(negedge clk_i) begin
        logic [64:0] e;
        if (!rst_i && inst_valid_o && !stall_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", inst_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("consumed_pc", pc_i, e[64:33]);
                chk("consumed_adel", {31'h0, inst_adel_o}, {31'h0, e[32]});
                chk("consumed_inst", inst_o, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Called one delta after a posedge with the DUT idle; leaves it idle with ce_i low.
    task automatic do_fetch(input logic [31:0] pc, input int ad, input int dd, input int stl,
                            input logic [31:0] exp_addr, input logic exp_adel,
                            input int exp_lat, input string tag);
        int          lat;
        logic        got;
        logic [31:0] exp_inst;
        addr_delay = ad;
        data_delay = dd;
        exp_inst   = exp_adel ? 32'h0 : mem_data(exp_addr);
        exp_q.push_back({pc, exp_adel, exp_inst});
        if (!exp_adel) exp_addr_q.push_back(exp_addr);
        pc_i = pc; ce_i = 1'b1; stall_i = (stl > 0);
        lat = 0; got = 1'b0;
        while (!got && lat < 60) begin
            step();
            lat++;
            got = inst_valid_o;
        end
        chk({tag, "_valid"}, {31'h0, got}, 32'h1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_stall_req_low"}, {31'h0, stall_req_o}, 32'h0);
        chk({tag, "_adel"}, {31'h0, inst_adel_o}, {31'h0, exp_adel});
        for (int i = 0; i < stl; i++) begin
            step();
            chk({tag, "_hold_state"}, {30'h0, dbg_state}, {30'h0, S_DONE});
            chk({tag, "_hold_inst"}, inst_o, exp_inst);
            chk({tag, "_hold_stall_req"}, {31'h0, stall_req_o}, 32'h0);
        end
        stall_i = 1'b0;
        step();
        chk({tag, "_idle_after_consume"}, {30'h0, dbg_state}, {30'h0, S_IDLE});
        ce_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        int          ad;
        int          dd;
        int          stl;
        logic [31:0] addr;
        logic        adel;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{32'hBFC0_0000, 0, 0, 0, 32'h1FC0_0000, 1'b0, 3};
        vecs[1] = '{32'hBFC0_0004, 4, 0, 0, 32'h1FC0_0004, 1'b0, 7};
        vecs[2] = '{32'hBFC0_0008, 0, 2, 5, 32'h1FC0_0008, 1'b0, 5};
        vecs[3] = '{32'hBFC0_0002, 0, 0, 0, 32'h0000_0000, 1'b1, 1};
        vecs[4] = '{32'h8000_1000, 1, 1, 2, 32'h0000_1000, 1'b0, 5};
        vecs[5] = '{32'h0040_0000, 0, 0, 0, 32'h0040_0000, 1'b0, 3};
        vecs[6] = '{32'hBFC0_0001, 0, 0, 3, 32'h0000_0000, 1'b1, 1};

        // ---- reset ----
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
        chk("rst_req", {31'h0, inst_req_o}, 32'h0);
        chk("rst_wr", {31'h0, inst_wr_o}, 32'h0);
        chk("rst_size", {30'h0, inst_size_o}, 32'h2);
        chk("rst_addr", inst_addr_o, 32'h0);
        chk("rst_wdata", inst_wdata_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rst_adel", {31'h0, inst_adel_o}, 32'h0);
        chk("rst_stall_req", {31'h0, stall_req_o}, 32'h0);
        step();
        rst_i = 1'b0;
        step();

        // ---- zero-wait fetch, cycle by cycle ----
        addr_delay = 0; data_delay = 0;
        exp_q.push_back({32'hBFC0_0000, 1'b0, 32'h3C08_BFC0});
        exp_addr_q.push_back(32'h1FC0_0000);
        pc_i = 32'hBFC0_0000; ce_i = 1'b1;
        @(negedge clk_i);
        chk("zw_n_stall_req", {31'h0, stall_req_o}, 32'h1);
        chk("zw_n_req", {31'h0, inst_req_o}, 32'h0);
        @(negedge clk_i);
        chk("zw_n1_req", {31'h0, inst_req_o}, 32'h1);
        chk("zw_n1_addr", inst_addr_o, 32'h1FC0_0000);
        chk("zw_n1_stall_req", {31'h0, stall_req_o}, 32'h1);
        @(negedge clk_i);
        chk("zw_n2_req", {31'h0, inst_req_o}, 32'h0);
        chk("zw_n2_state", {30'h0, dbg_state}, {30'h0, S_WAIT});
        chk("zw_n2_stall_req", {31'h0, stall_req_o}, 32'h1);
        @(negedge clk_i);
        chk("zw_n3_valid", {31'h0, inst_valid_o}, 32'h1);
        chk("zw_n3_inst", inst_o, 32'h3C08_BFC0);
        chk("zw_n3_stall_req", {31'h0, stall_req_o}, 32'h0);
        step();
        ce_i = 1'b0;
        chk("zw_idle", {30'h0, dbg_state}, {30'h0, S_IDLE});

        // ---- vector table ----
        for (int i = 0; i < 7; i++) begin
            do_fetch(vecs[i].pc, vecs[i].ad, vecs[i].dd, vecs[i].stl, vecs[i].addr,
                     vecs[i].adel, vecs[i].lat, $sformatf("v%0d", i));
        end

        // ---- flush while waiting for data ----
        addr_delay = 0; data_delay = 3;
        exp_addr_q.push_back(32'h1FC0_0100);
        pc_i = 32'hBFC0_0100; ce_i = 1'b1;
        n = 0;
        while (dbg_state != S_WAIT && n < 20) begin
            step();
            n++;
        end
        chk("fl_reached_wait", {30'h0, dbg_state}, {30'h0, S_WAIT});
        pc_i = 32'hBFC0_0380; flush_i = 1'b1;
        exp_addr_q.push_back(32'h1FC0_0380);
        exp_q.push_back({32'hBFC0_0380, 1'b0, mem_data(32'h1FC0_0380)});
        step();
        flush_i = 1'b0;
        chk("fl_still_wait", {30'h0, dbg_state}, {30'h0, S_WAIT});
        n = 0;
        while (!inst_valid_o && n < 40) begin
            step();
            n++;
            if (n == 5) data_delay = 0;
        end
        chk("fl_new_valid", {31'h0, inst_valid_o}, 32'h1);
        chk("fl_new_inst", inst_o, mem_data(32'h1FC0_0380));
        step();
        ce_i = 1'b0;
        chk("fl_idle", {30'h0, dbg_state}, {30'h0, S_IDLE});
        data_delay = 0;

        // ---- reset while a request is pending ----
        addr_delay = 10;
        pc_i = 32'hBFC0_0200; ce_i = 1'b1;
        n = 0;
        while (!inst_req_o && n < 10) begin
            step();
            n++;
        end
        chk("rr_req_up", {31'h0, inst_req_o}, 32'h1);
        rst_i = 1'b1; ce_i = 1'b0;
        step();
        chk("rr_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
        chk("rr_req", {31'h0, inst_req_o}, 32'h0);
        chk("rr_addr", inst_addr_o, 32'h0);
        chk("rr_inst", inst_o, 32'h0);
        chk("rr_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rr_stall_req", {31'h0, stall_req_o}, 32'h0);
        rst_i = 1'b0;
        step();
        do_fetch(32'hBFC0_0200, 0, 0, 0, 32'h1FC0_0200, 1'b0, 3, "post_rst");

        repeat (3) step();
        chk("exp_q_drained", exp_q.size(), 0);
        chk("addr_q_drained", exp_addr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
